// File: rtl/pc_ctl_if.sv
// pc_ctl_if: fetch/execute-facing signal bundle of the PC sequencer.
//   master modport: the sequencer (pc_ctl) side.
//   slave  modport: the environment side (fetch + execute).
// Signals:
//   inst_valid_i  fetch valid level (high 2 cycles per instruction)
//   stall_i       hold PC, suppress advance
//   redir_i       one-cycle redirect request from execute
//   redir_pc_i    redirect target, sampled with redir_i
//   pc_o          PC presented to the fetch unit
//   squash_o      current delivered instruction is wrong-path
//   fault_o       sticky misaligned-redirect fault
//   adv_cnt_o / squash_cnt_o  performance counters, present only when
//                 SKYWAVE_PC_PERF_EN is defined
interface pc_ctl_if #(
  parameter int unsigned AD_LEN = 32
);
  logic              inst_valid_i;
  logic              stall_i;
  logic              redir_i;
  logic [AD_LEN-1:0] redir_pc_i;
  logic [AD_LEN-1:0] pc_o;
  logic              squash_o;
  logic              fault_o;
`ifdef SKYWAVE_PC_PERF_EN
  logic [31:0]       adv_cnt_o;
  logic [31:0]       squash_cnt_o;
`endif

  modport master (
    input  inst_valid_i,
    input  stall_i,
    input  redir_i,
    input  redir_pc_i,
    output pc_o,
    output squash_o,
`ifdef SKYWAVE_PC_PERF_EN
    output adv_cnt_o,
    output squash_cnt_o,
`endif
    output fault_o
  );

  modport slave (
    output inst_valid_i,
    output stall_i,
    output redir_i,
    output redir_pc_i,
    input  pc_o,
    input  squash_o,
`ifdef SKYWAVE_PC_PERF_EN
    input  adv_cnt_o,
    input  squash_cnt_o,
`endif
    input  fault_o
  );
endinterface

// File: rtl/pc_ctl.sv
// pc_ctl: program-counter sequencer directly upstream of the fetch unit.
// Advances the PC once per delivered instruction (rising edge of the fetch
// valid level), applies execute redirects at the next advance and flags
// wrong-path instructions with squash_o.
// Ports:
//   clk_i    clock, all state updates on posedge
//   reset_i  synchronous active-high reset
//   bus      pc_ctl_if.master: inst_valid_i, stall_i, redir_i, redir_pc_i
//            in; pc_o, squash_o, fault_o out (plus adv_cnt_o/squash_cnt_o
//            when SKYWAVE_PC_PERF_EN is defined)
// Configuration macro: SKYWAVE_PC_PERF_EN enables the performance counters.
module pc_ctl #(
  parameter int unsigned        AD_LEN     = 32,
  parameter logic [AD_LEN-1:0]  RESET_VEC  = '0,
  parameter int unsigned        INST_BYTES = 4
) (
  input logic      clk_i,
  input logic      reset_i,
  pc_ctl_if.master bus
);

  localparam logic [AD_LEN-1:0] INC = AD_LEN'(INST_BYTES);

  logic [AD_LEN-1:0] r_pc;
  logic [AD_LEN-1:0] r_tgt;
  logic              r_pend;
  logic              r_squash;
  logic              r_fault;
  logic              r_vprev;

  logic w_adv;
  logic w_fall;
  logic w_adv_go;
  logic w_redir_ok;
  logic w_redir_bad;

  always_comb begin
    w_adv       = bus.inst_valid_i & ~r_vprev;
    w_fall      = ~bus.inst_valid_i & r_vprev;
    w_adv_go    = w_adv & ~bus.stall_i;
    w_redir_ok  = bus.redir_i & (bus.redir_pc_i[1:0] == 2'b00);
    w_redir_bad = bus.redir_i & (bus.redir_pc_i[1:0] != 2'b00);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc     <= RESET_VEC;
      r_tgt    <= '0;
      r_pend   <= 1'b0;
      r_squash <= 1'b0;
      r_fault  <= 1'b0;
      r_vprev  <= 1'b0;
    end else begin
      r_vprev <= bus.inst_valid_i;

      // A redirect arriving with an unstalled advance bypasses the pending
      // register; otherwise it is parked (latest wins) until the next advance.
      if (w_adv_go) begin
        if (w_redir_ok) begin
          r_pc   <= bus.redir_pc_i;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_pc   <= r_tgt;
          r_pend <= 1'b0;
        end else begin
          r_pc <= r_pc + INC;
        end
      end else if (w_redir_ok) begin
        r_tgt  <= bus.redir_pc_i;
        r_pend <= 1'b1;
      end

      // Set beats clear; a still-pending redirect keeps the window open.
      if (w_redir_ok)
        r_squash <= 1'b1;
      else if (w_fall && !r_pend)
        r_squash <= 1'b0;

      if (w_redir_bad)
        r_fault <= 1'b1;
    end
  end

  assign bus.pc_o     = r_pc;
  assign bus.squash_o = r_squash;
  assign bus.fault_o  = r_fault;

`ifdef SKYWAVE_PC_PERF_EN
  logic [31:0] r_adv_cnt;
  logic [31:0] r_squash_cnt;

  // An advance can never coincide with a fall, so the post-edge squash
  // value is simply the current one or a newly accepted redirect.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_adv_cnt    <= '0;
      r_squash_cnt <= '0;
    end else if (w_adv_go) begin
      r_adv_cnt <= r_adv_cnt + 32'd1;
      if (r_squash || w_redir_ok)
        r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end

  assign bus.adv_cnt_o    = r_adv_cnt;
  assign bus.squash_cnt_o = r_squash_cnt;
`endif

endmodule

// File: tb/tb_pc_ctl.sv
module tb_pc_ctl;

  typedef struct {
    logic [31:0] pc;
    logic        sq;
    logic        flt;
    string       name;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  pc_ctl_if #(.AD_LEN(32)) bus ();

  pc_ctl #(
    .AD_LEN(32),
    .RESET_VEC(32'h0000_0100),
    .INST_BYTES(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .bus(bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_ev(input logic [31:0] pc, input logic sq, input logic flt,
                           input string name);
    exp_t e;
    e.pc = pc; e.sq = sq; e.flt = flt; e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string name);
    expect_ev(32'h100, 1'b0, 1'b0, name);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
  endtask

  // One instruction: valid high two cycles, low two cycles.
  task automatic instr(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic [31:0] pc, input logic sq, input logic flt,
                       input string name);
    expect_ev(pc, sq, flt, name);
    bus.inst_valid_i = 1'b1;
    bus.stall_i      = stall;
    bus.redir_i      = redir;
    bus.redir_pc_i   = rpc;
    step();
    bus.stall_i = 1'b0;
    bus.redir_i = 1'b0;
    step();
    bus.inst_valid_i = 1'b0;
    step();
    step();
  endtask

  task automatic redirect(input logic [31:0] rpc, input logic [31:0] pc,
                          input logic sq, input logic flt, input string name);
    expect_ev(pc, sq, flt, name);
    bus.redir_i    = 1'b1;
    bus.redir_pc_i = rpc;
    step();
    bus.redir_i = 1'b0;
    step();
  endtask

  // Monitor: the DUT presents a new state after any edge carrying reset,
  // a valid rise or a redirect; compare that state at the following negedge.
  initial begin : monitor
    logic prev;
    logic ev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk_i);
      ev   = reset_i | (bus.inst_valid_i & ~prev) | bus.redir_i;
      prev = reset_i ? 1'b0 : bus.inst_valid_i;
      if (ev && !done) begin
        @(negedge clk_i);
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_event: pc=%h sq=%b flt=%b, no expected entry",
                   bus.pc_o, bus.squash_o, bus.fault_o);
        end else begin
          e = sb.pop_front();
          if (bus.pc_o === e.pc && bus.squash_o === e.sq && bus.fault_o === e.flt)
            n_pass++;
          else
            $display("FAIL %s: got pc=%h sq=%b flt=%b, expected pc=%h sq=%b flt=%b",
                     e.name, bus.pc_o, bus.squash_o, bus.fault_o, e.pc, e.sq, e.flt);
        end
      end
    end
  end

  initial begin
    reset_i          = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.stall_i      = 1'b0;
    bus.redir_i      = 1'b0;
    bus.redir_pc_i   = '0;
    step();

    // Sequential advance from the reset vector
    do_reset("reset");
    instr(0, 0, 0, 32'h104, 0, 0, "seq1");
    instr(0, 0, 0, 32'h108, 0, 0, "seq2");
    instr(0, 0, 0, 32'h10C, 0, 0, "seq3");

    // Single redirect between advances
    redirect(32'h2000, 32'h10C, 1, 0, "redir_2000_sq");
    instr(0, 0, 0, 32'h2000, 1, 0, "redir_2000_taken");
    instr(0, 0, 0, 32'h2004, 0, 0, "redir_2000_cleared");

    // Two redirects before an advance: latest wins, one squash window
    redirect(32'h3000, 32'h2004, 1, 0, "redir_3000");
    redirect(32'h4000, 32'h2004, 1, 0, "redir_4000");
    instr(0, 0, 0, 32'h4000, 1, 0, "latest_wins");
    instr(0, 0, 0, 32'h4004, 0, 0, "after_latest");

    // Redirect coinciding with an unstalled advance
    instr(0, 1, 32'h5000, 32'h5000, 1, 0, "redir_with_adv");
    instr(0, 0, 0, 32'h5004, 0, 0, "after_redir_with_adv");

    // Stall over an advance
    do_reset("reset2");
    instr(0, 0, 0, 32'h104, 0, 0, "pre_stall");
    instr(1, 0, 0, 32'h104, 0, 0, "stalled_hold");
    instr(0, 0, 0, 32'h108, 0, 0, "stall_release");

    // Stalled advance retains a pending redirect and its squash window
    redirect(32'h6000, 32'h108, 1, 0, "redir_6000");
    instr(1, 0, 0, 32'h108, 1, 0, "stall_keeps_pend");
    instr(0, 0, 0, 32'h6000, 1, 0, "pend_consumed");
    instr(0, 0, 0, 32'h6004, 0, 0, "after_pend");

    // Misaligned redirect: dropped, sticky fault
    redirect(32'h2002, 32'h6004, 0, 1, "misaligned");
    instr(0, 0, 0, 32'h6008, 0, 1, "fault_sticky_seq");
    redirect(32'h7000, 32'h6008, 1, 1, "redir_after_fault");
    instr(0, 0, 0, 32'h7000, 1, 1, "taken_after_fault");
    instr(0, 0, 0, 32'h7004, 0, 1, "fault_still_set");
    do_reset("reset_clears_fault");

    // Wrap modulo 2^32
    redirect(32'hFFFF_FFF8, 32'h100, 1, 0, "redir_top");
    instr(0, 0, 0, 32'hFFFF_FFF8, 1, 0, "top_taken");
    instr(0, 0, 0, 32'hFFFF_FFFC, 0, 0, "top_last");
    instr(0, 0, 0, 32'h0000_0000, 0, 0, "wrap_zero");

    // Reset while a redirect is pending
    redirect(32'h8000, 32'h0, 1, 0, "redir_8000");
    do_reset("reset_mid_pending");
    instr(0, 0, 0, 32'h104, 0, 0, "pending_lost");

    repeat (4) step();
    done = 1'b1;
    n_checks++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL missing_events: %0d expected entries left, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
